vproc_simctrl_arbiter: RTL and testbench
========================================

// Module: vproc_simctrl_arbiter
// PURPOSE
//  Shares one simulation-control register space among NUM_NODES VProc nodes.
//  Each node's memory-mapped bus (addr/dataout/we/rd) is arbitrated round-robin.
//  The granted access is performed against the control registers: cycle count,
//  clock period, finish vote mask and timeout.
//  It drives a synthesizable finish request; the testbench top turns that into $finish.
// PARAMETERS
//  NUM_NODES      4      number of requesting VProc nodes (1..16)
//  CLK_PERIOD_PS  10000  value returned at VSC_CLK_PERIOD_ADDR
//  NODE_MASK      'hF    nodes whose finish vote counts; bit i = node i
//  FINISH_ALL     1      1: finish when all NODE_MASK nodes voted; 0: any one vote
//  TIMEOUT_CYCLES 0      cycle_count value that forces finish; 0 disables
// PORTS
//  clk          in   1              simulation clock, all logic on posedge
//  rst          in   1              asynchronous, active-high reset
//  addr         in   NUM_NODES*32   per-node address, node i at [i*32 +: 32]
//  dataout      in   NUM_NODES*32   per-node write data
//  we           in   NUM_NODES      per-node write request, held until wrack
//  rd           in   NUM_NODES      per-node read request, held until rdack
//  wrack        out  NUM_NODES      one-cycle write acknowledge
//  rdack        out  NUM_NODES      one-cycle read acknowledge
//  datain       out  NUM_NODES*32   per-node read data, valid while rdack[i]=1
//  cycle_count  out  32             free-running cycle counter
//  finish       out  1              sticky finish request
//  timed_out    out  1              sticky; finish was caused by timeout
// BEHAVIOUR
//  Reset values
//   - All outputs are 0 on reset.
//   - Vote mask = 0, RR pointer = 0, FSM = IDLE.
//   - Reset mid-access drops the grant; no ack is issued.
//  cycle_count
//   - Increments every posedge regardless of FSM state.
//   - Wraps 32'hFFFFFFFF -> 0.
//  FSM
//   - IDLE: req = we|rd. If req != 0, select the first requester at or after
//     the RR pointer (modulo NUM_NODES), latch its index, -> ACCESS.
//   - ACCESS (1 cycle):
//     - Perform the access and pulse wrack[g] and/or rdack[g].
//     - datain[g] is registered and valid in the same cycle as rdack.
//     - RR pointer <= g+1, with wrap from NUM_NODES-1 to 0.
//     - Next state -> RELEASE.
//   - RELEASE (1 cycle): no sampling. This lets the requester drop we/rd, so a
//     held request is never double-serviced. Next state -> IDLE.
//   - Latency: request seen in IDLE at cycle 0 -> ack at cycle 1.
//   - Throughput: at most one access per 3 cycles.
//  Simultaneous we & rd from the granted node
//   - The write is performed and both acks pulse.
//   - datain returns the pre-write value.
//  Read map (default read returns 0)
//   - VSC_CYC_COUNT_ADDR: cycle_count sampled in ACCESS.
//   - VSC_CLK_PERIOD_ADDR: CLK_PERIOD_PS.
//   - VSC_VOTE_ADDR: zero-extended vote mask.
//   - VSC_NODE_ID_ADDR: index of the granted node.
//  Write map (writes to other addresses are acked and ignored)
//   - VSC_FINISH_ADDR: dataout[0]=1 sets vote[g]; dataout[0]=0 clears it.
//  Finish
//   - finish sets on the cycle after the condition becomes true:
//     - FINISH_ALL=1: (vote & NODE_MASK) == NODE_MASK
//     - FINISH_ALL=0: (vote & NODE_MASK) != 0
//     - TIMEOUT_CYCLES != 0 and cycle_count == TIMEOUT_CYCLES (also sets timed_out).
//   - Once set, finish stays set and the FSM keeps servicing accesses.
//   - Votes from nodes outside NODE_MASK are recorded but never counted.
// STRUCTURE
//  - Package vproc_simctrl_pkg holds:
//    - VSC_* address constants; existing header values plus VSC_VOTE_ADDR and VSC_NODE_ID_ADDR.
//    - typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} vsc_arb_state_t.
//  - Sub-module vsc_rr_arbiter (request vector + pointer -> grant index, valid),
//    purely combinational. Register file and FSM live in the top.
// TESTING
//  1. Reset -> all outputs 0. Release reset -> cycle_count = 5 after 5 posedges.
//  2. Node0 rd at VSC_CLK_PERIOD_ADDR -> rdack[0] one cycle after IDLE sample,
//     datain[0] = 10000; a held rd yields no second ack in RELEASE.
//  3. we = 4'b1111 all held at once -> acks in order 0,1,2,3,
//     each 3 cycles apart.
//  4. FINISH_ALL=1, NODE_MASK=4'b0011: node0 votes -> finish=0.
//     Node2 votes -> finish=0. Node1 votes -> finish=1 the next cycle.
//     Node0 then writes 0 -> finish stays 1.
//  5. TIMEOUT_CYCLES=100, no votes -> finish=1 and timed_out=1 at cycle 101.
//  6. Node1 we & rd at VSC_FINISH_ADDR -> both acks pulse. Assert rst in
//     ACCESS -> acks drop immediately, vote mask = 0.

Source files
------------

// File: rtl/vproc_simctrl_pkg.sv
// Shared definitions for the VProc simulation-control arbiter.
// Address map of the control registers and the arbiter FSM state type.
package vproc_simctrl_pkg;

  localparam logic [31:0] VSC_CYC_COUNT_ADDR  = 32'hAFFF_FFF0;
  localparam logic [31:0] VSC_CLK_PERIOD_ADDR = 32'hAFFF_FFF4;
  localparam logic [31:0] VSC_FINISH_ADDR     = 32'hAFFF_FFF8;
  localparam logic [31:0] VSC_VOTE_ADDR       = 32'hAFFF_FFFC;
  localparam logic [31:0] VSC_NODE_ID_ADDR    = 32'hAFFF_FFEC;

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} vsc_arb_state_t;

endpackage

// File: rtl/vsc_rr_arbiter.sv
// Combinational round-robin selector.
//  req   : one request bit per node
//  ptr   : node with highest priority this round (must be < NUM_NODES)
//  gnt   : index of the first requester at or after ptr, modulo NUM_NODES
//  valid : at least one request present
module vsc_rr_arbiter #(
  parameter int unsigned NUM_NODES = 4,
  parameter int unsigned IW        = 2
) (
  input  logic [NUM_NODES-1:0] req,
  input  logic [IW-1:0]        ptr,
  output logic [IW-1:0]        gnt,
  output logic                 valid
);

  always_comb begin
    logic [IW-1:0] idx;
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_NODES; i++) begin
      idx = IW'((32'(ptr) + i) % NUM_NODES);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        gnt   = idx;
      end
    end
  end

endmodule

// File: rtl/vproc_simctrl_arbiter.sv
// Round-robin arbiter sharing the simulation-control registers among
// NUM_NODES VProc memory-mapped buses.
//  clk, rst            : clock, asynchronous active-high reset
//  addr/dataout/we/rd  : per-node bus, node i in slice i (32-bit fields)
//  wrack/rdack         : one-cycle acknowledges to the granted node
//  datain              : per-node registered read data, valid with rdack
//  cycle_count         : free-running cycle counter
//  finish, timed_out   : sticky finish request, and whether timeout caused it
module vproc_simctrl_arbiter
  import vproc_simctrl_pkg::*;
#(
  parameter int unsigned NUM_NODES      = 4,
  parameter int unsigned CLK_PERIOD_PS  = 10000,
  parameter logic [15:0] NODE_MASK      = 16'hF,
  parameter bit          FINISH_ALL     = 1'b1,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_NODES*32-1:0] addr,
  input  logic [NUM_NODES*32-1:0] dataout,
  input  logic [NUM_NODES-1:0]    we,
  input  logic [NUM_NODES-1:0]    rd,
  output logic [NUM_NODES-1:0]    wrack,
  output logic [NUM_NODES-1:0]    rdack,
  output logic [NUM_NODES*32-1:0] datain,
  output logic [31:0]             cycle_count,
  output logic                    finish,
  output logic                    timed_out
);

  localparam int unsigned          IW   = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam logic [NUM_NODES-1:0] MASK = NODE_MASK[NUM_NODES-1:0];

  vsc_arb_state_t       state, state_nxt;
  logic [31:0]          addr_a   [NUM_NODES];
  logic [31:0]          datain_a [NUM_NODES];
  logic [NUM_NODES-1:0] wbit;
  logic [NUM_NODES-1:0] req;
  logic [IW-1:0]        arb_gnt, gnt_q, ptr_q;
  logic                 arb_valid, take;
  logic                 wr_q, rd_q;
  logic [NUM_NODES-1:0] vote_q;
  logic [31:0]          cnt_q, rd_val;
  logic                 fin_q, to_q, fin_cond, to_cond;
  logic                 unused_dout;

  for (genvar i = 0; i < NUM_NODES; i++) begin : g_node
    assign addr_a[i]          = addr[i*32 +: 32];
    assign wbit[i]            = dataout[i*32];
    assign datain[i*32 +: 32] = datain_a[i];
  end

  // Only bit 0 of the write data has meaning.
  assign unused_dout = ^dataout;

  assign req  = we | rd;
  assign take = (state == IDLE) && arb_valid;

  vsc_rr_arbiter #(
    .NUM_NODES (NUM_NODES),
    .IW        (IW)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (arb_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: acks are high for the whole ACCESS cycle, so reset drops them at once
  always_comb begin
    wrack = '0;
    rdack = '0;
    if (state == ACCESS) begin
      wrack[gnt_q] = wr_q;
      rdack[gnt_q] = rd_q;
    end
  end

  // Read data is computed in IDLE and registered so it is valid with rdack in
  // ACCESS; the counter term adds one so it returns the value seen in ACCESS.
  always_comb begin
    unique case (addr_a[arb_gnt])
      VSC_CYC_COUNT_ADDR:  rd_val = cnt_q + 32'd1;
      VSC_CLK_PERIOD_ADDR: rd_val = 32'(CLK_PERIOD_PS);
      VSC_VOTE_ADDR:       rd_val = 32'(vote_q);
      VSC_NODE_ID_ADDR:    rd_val = 32'(arb_gnt);
      default:             rd_val = '0;
    endcase
  end

  // Access datapath. The vote update lands on the same edge as the read
  // capture, so a simultaneous read sees the pre-write register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q  <= '0;
      ptr_q  <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      vote_q <= '0;
      for (int unsigned i = 0; i < NUM_NODES; i++) datain_a[i] <= '0;
    end else begin
      if (take) begin
        gnt_q <= arb_gnt;
        wr_q  <= we[arb_gnt];
        rd_q  <= rd[arb_gnt];
        if (rd[arb_gnt]) datain_a[arb_gnt] <= rd_val;
        if (we[arb_gnt] && (addr_a[arb_gnt] == VSC_FINISH_ADDR))
          vote_q[arb_gnt] <= wbit[arb_gnt];
      end
      if (state == ACCESS)
        ptr_q <= (gnt_q == IW'(NUM_NODES - 1)) ? '0 : gnt_q + 1'b1;
    end
  end

  always_comb begin
    fin_cond = FINISH_ALL ? ((vote_q & MASK) == MASK) : (|(vote_q & MASK));
    to_cond  = (TIMEOUT_CYCLES != 32'd0) && (cnt_q == TIMEOUT_CYCLES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      fin_q <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
      fin_q <= fin_q | fin_cond | to_cond;
      to_q  <= to_q | (to_cond & ~fin_q);
    end
  end

  assign cycle_count = cnt_q;
  assign finish      = fin_q;
  assign timed_out   = to_q;

endmodule

// File: tb/tb_vproc_simctrl_arbiter.sv
module tb_vproc_simctrl_arbiter;
  import vproc_simctrl_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_b;
  logic [N*32-1:0] addr, dataout, datain;
  logic [N-1:0]    we, rd, wrack, rdack;
  logic [31:0]     cycle_count;
  logic            finish, timed_out;

  logic [N*32-1:0] b_zero32;
  logic [N-1:0]    b_zero, b_wrack, b_rdack;
  logic [N*32-1:0] b_datain;
  logic [31:0]     b_cycle;
  logic            b_finish, b_timed_out;

  vproc_simctrl_arbiter #(
    .NUM_NODES(4), .CLK_PERIOD_PS(10000), .NODE_MASK(16'h0003),
    .FINISH_ALL(1'b1), .TIMEOUT_CYCLES(32'd0)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .dataout(dataout), .we(we), .rd(rd),
    .wrack(wrack), .rdack(rdack), .datain(datain), .cycle_count(cycle_count),
    .finish(finish), .timed_out(timed_out)
  );

  vproc_simctrl_arbiter #(
    .NUM_NODES(4), .CLK_PERIOD_PS(10000), .NODE_MASK(16'h000F),
    .FINISH_ALL(1'b1), .TIMEOUT_CYCLES(32'd100)
  ) dut_to (
    .clk(clk), .rst(rst_b), .addr(b_zero32), .dataout(b_zero32), .we(b_zero), .rd(b_zero),
    .wrack(b_wrack), .rdack(b_rdack), .datain(b_datain), .cycle_count(b_cycle),
    .finish(b_finish), .timed_out(b_timed_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference cycle counter: posedges since reset release
  int unsigned tcyc;
  always @(posedge clk or posedge rst)
    if (rst) tcyc <= 0;
    else     tcyc <= tcyc + 1;

  // Reference state for the randomized phase
  int        mptr;
  bit [3:0]  mvote;
  bit        mfin;

  typedef struct {
    int          node;
    bit          w;
    bit          r;
    logic [31:0] a;
    logic [31:0] d;
    bit          is_cyc;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int n, input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    addr[n*32 +: 32]    = a;
    dataout[n*32 +: 32] = d;
    we[n] = w;
    rd[n] = r;
  endtask

  task automatic drop(input int n);
    we[n] = 1'b0;
    rd[n] = 1'b0;
  endtask

  // Issue one request from an idle bus; returns ack info and latency in cycles
  // (0 = no ack within the bound). Leaves the bus idle for the next call.
  task automatic access(input int n, input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, output logic gw, output logic gr,
                        output logic [31:0] gd, output logic [31:0] gcyc, output int lat);
    drive(n, w, r, a, d);
    lat = 0; gw = 0; gr = 0; gd = '0; gcyc = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (wrack[n] | rdack[n]) begin
        gw = wrack[n]; gr = rdack[n]; gd = datain[n*32 +: 32]; gcyc = tcyc; lat = k;
        break;
      end
    end
    drop(n);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input int g, input int unsigned cyc, input bit [3:0] v);
    case (a)
      VSC_CYC_COUNT_ADDR:  return cyc;
      VSC_CLK_PERIOD_ADDR: return 32'd10000;
      VSC_VOTE_ADDR:       return {28'd0, v};
      VSC_NODE_ID_ADDR:    return g;
      default:             return 32'd0;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        gw, gr;
    logic [31:0] gd, gc;
    int          lat;
    int          order[4];
    int unsigned when[4];
    int          got;
    logic [31:0] alist[6];

    rst = 1'b1; rst_b = 1'b1;
    addr = '0; dataout = '0; we = '0; rd = '0;
    b_zero32 = '0; b_zero = '0;

    tbl[0]  = '{1, 1'b0, 1'b1, VSC_CLK_PERIOD_ADDR, 32'd0, 1'b0, 32'd10000};
    tbl[1]  = '{2, 1'b0, 1'b1, VSC_NODE_ID_ADDR,    32'd0, 1'b0, 32'd2};
    tbl[2]  = '{3, 1'b0, 1'b1, 32'h0000_1234,       32'd0, 1'b0, 32'd0};
    tbl[3]  = '{3, 1'b1, 1'b0, VSC_FINISH_ADDR,     32'd1, 1'b0, 32'd0};
    tbl[4]  = '{0, 1'b0, 1'b1, VSC_VOTE_ADDR,       32'd0, 1'b0, 32'd8};
    tbl[5]  = '{2, 1'b1, 1'b0, VSC_FINISH_ADDR,     32'd1, 1'b0, 32'd0};
    tbl[6]  = '{1, 1'b0, 1'b1, VSC_VOTE_ADDR,       32'd0, 1'b0, 32'd12};
    tbl[7]  = '{3, 1'b1, 1'b0, VSC_FINISH_ADDR,     32'd0, 1'b0, 32'd0};
    tbl[8]  = '{2, 1'b1, 1'b0, VSC_FINISH_ADDR,     32'hFFFF_FFFE, 1'b0, 32'd0};
    tbl[9]  = '{0, 1'b0, 1'b1, VSC_VOTE_ADDR,       32'd0, 1'b0, 32'd0};
    tbl[10] = '{2, 1'b1, 1'b0, 32'h0000_0040,       32'd1, 1'b0, 32'd0};
    tbl[11] = '{3, 1'b0, 1'b1, VSC_VOTE_ADDR,       32'd0, 1'b0, 32'd0};
    tbl[12] = '{1, 1'b0, 1'b1, VSC_CYC_COUNT_ADDR,  32'd0, 1'b1, 32'd0};

    alist[0] = VSC_CYC_COUNT_ADDR; alist[1] = VSC_CLK_PERIOD_ADDR;
    alist[2] = VSC_VOTE_ADDR;      alist[3] = VSC_NODE_ID_ADDR;
    alist[4] = VSC_FINISH_ADDR;    alist[5] = 32'h0000_1234;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_wrack", wrack, 0);
    check("rst_rdack", rdack, 0);
    check("rst_datain", datain, 0);
    check("rst_cycle", cycle_count, 0);
    check("rst_finish", {finish, timed_out}, 0);

    // Counter after 5 posedges, timeout instance at cycles 100/101
    rst = 1'b0; rst_b = 1'b0;
    repeat (5) @(negedge clk);
    check("cycle_5", cycle_count, 5);
    check("cycle_5_b", b_cycle, 5);
    repeat (95) @(negedge clk);
    check("to_fin_100", {b_finish, b_timed_out}, 2'b00);
    @(negedge clk);
    check("to_fin_101", {b_finish, b_timed_out}, 2'b11);
    check("no_to_fin", {finish, timed_out}, 2'b00);

    // All four nodes write at once: served 0,1,2,3 three cycles apart
    for (int n = 0; n < 4; n++) drive(n, 1'b1, 1'b0, 32'h0, 32'h0);
    got = 0;
    for (int k = 0; k < 20 && got < 4; k++) begin
      @(negedge clk);
      for (int n = 0; n < 4; n++)
        if (wrack[n] && got < 4) begin
          order[got] = n; when[got] = tcyc; got++; drop(n);
        end
      check("burst_no_rdack", rdack, 0);
    end
    check("burst_count", got, 4);
    for (int i = 0; i < 4 && i < got; i++) begin
      check($sformatf("burst_order%0d", i), order[i], i);
      if (i > 0) check($sformatf("burst_gap%0d", i), when[i] - when[i-1], 3);
    end
    repeat (2) @(negedge clk);

    // Node0 read of clock period, held over RELEASE
    drive(0, 1'b0, 1'b1, VSC_CLK_PERIOD_ADDR, 32'd0);
    @(negedge clk);
    check("clk_rdack", rdack[0], 1);
    check("clk_datain", datain[31:0], 10000);
    @(negedge clk);
    check("held_no_rdack", rdack, 0);
    drop(0);
    repeat (3) @(negedge clk);
    check("held_still_none", rdack, 0);

    // Table of single accesses
    for (int i = 0; i < 13; i++) begin
      access(tbl[i].node, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, gw, gr, gd, gc, lat);
      check($sformatf("tbl%0d_lat", i), lat, 1);
      check($sformatf("tbl%0d_acks", i), {gw, gr}, {tbl[i].w, tbl[i].r});
      if (tbl[i].r)
        check($sformatf("tbl%0d_data", i), gd, tbl[i].is_cyc ? gc : tbl[i].exp);
    end
    check("tbl_finish", finish, 0);

    // Finish vote sequence (mask = nodes 0,1, all must vote)
    access(0, 1'b1, 1'b0, VSC_FINISH_ADDR, 32'd1, gw, gr, gd, gc, lat);
    check("vote0_finish", finish, 0);
    access(2, 1'b1, 1'b0, VSC_FINISH_ADDR, 32'd1, gw, gr, gd, gc, lat);
    check("vote2_finish", finish, 0);
    drive(1, 1'b1, 1'b0, VSC_FINISH_ADDR, 32'd1);
    @(negedge clk);
    check("vote1_ack", wrack[1], 1);
    check("vote1_finish_same", finish, 0);
    drop(1);
    @(negedge clk);
    check("vote1_finish_next", finish, 1);
    @(negedge clk);
    access(0, 1'b1, 1'b0, VSC_FINISH_ADDR, 32'd0, gw, gr, gd, gc, lat);
    check("unvote_finish_sticky", {finish, timed_out}, 2'b10);

    // Reset in the middle of a combined write+read
    rst = 1'b1; @(negedge clk); rst = 1'b0; repeat (2) @(negedge clk);
    drive(1, 1'b1, 1'b1, VSC_FINISH_ADDR, 32'd1);
    @(negedge clk);
    check("wr_rd_acks", {wrack[1], rdack[1]}, 2'b11);
    check("wr_rd_data", datain[63:32], 0);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_acks", {wrack, rdack}, 0);
    check("rst_mid_fin", {finish, cycle_count}, 0);
    @(negedge clk);
    rst = 1'b0;
    drop(1);
    repeat (2) @(negedge clk);
    access(0, 1'b0, 1'b1, VSC_VOTE_ADDR, 32'd0, gw, gr, gd, gc, lat);
    check("rst_mid_vote", gd, 0);

    // Randomized bursts against the reference model
    rst = 1'b1; @(negedge clk); rst = 1'b0; repeat (2) @(negedge clk);
    mptr = 0; mvote = '0; mfin = 1'b0;
    for (int b = 0; b < 30; b++) begin
      bit [3:0]    pend;
      bit          pw[4], pr[4];
      logic [31:0] pa[4], pd[4];
      pend = 4'($urandom_range(1, 15));
      for (int n = 0; n < 4; n++) begin
        pw[n] = 1'($urandom); pr[n] = 1'($urandom);
        if (!pw[n] && !pr[n]) pr[n] = 1'b1;
        pa[n] = alist[$urandom_range(0, 5)];
        pd[n] = $urandom;
        if (pend[n]) drive(n, pw[n], pr[n], pa[n], pd[n]);
      end
      while (pend != 0) begin
        int g, a;
        bit seen;
        g = -1;
        for (int i = 0; i < 4; i++)
          if (g < 0 && pend[(mptr + i) % 4]) g = (mptr + i) % 4;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
          @(negedge clk);
          if ((wrack | rdack) != 0) seen = 1'b1;
        end
        if (!seen) begin
          check("rand_ack_timeout", 0, 1);
          break;
        end
        a = -1;
        for (int n = 3; n >= 0; n--) if (wrack[n] | rdack[n]) a = n;
        check("rand_grant", a, g);
        check("rand_acks", {wrack[g], rdack[g]}, {pw[g], pr[g]});
        if (pr[g]) check("rand_data", datain[g*32 +: 32], model_read(pa[g], g, tcyc, mvote));
        if (pw[g] && pa[g] == VSC_FINISH_ADDR) mvote[g] = pd[g][0];
        if (mvote[0] && mvote[1]) mfin = 1'b1;
        pend[g] = 1'b0;
        drop(g);
        if (a >= 0) begin pend[a] = 1'b0; drop(a); end
        mptr = (g + 1) % 4;
      end
      repeat (2) @(negedge clk);
      check("rand_finish", {finish, timed_out}, {mfin, 1'b0});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
